// File: rtl/rv32i_types.sv
// Shared front-end types: the fetch queue entry handed to decode and the fetch FSM states.
package rv32i_types;

    typedef struct packed {
        logic [31:0] inst;
        logic [63:0] order;
        logic [31:0] pc;
        logic [31:0] pc_next;
    } fetch_queue_t;

    typedef enum logic [1:0] {REQ, WAIT, DROP} fetch_state_t;

    localparam logic [31:0] PC_STEP = 32'd4;

    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Circular buffer of fetch entries; pointers carry an extra wrap bit so full and empty differ.
module fetch_fifo
    import rv32i_types::*;
#(
    parameter int  DEPTH = 8,
    parameter type T     = fetch_queue_t
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enq,
    input  T                       enq_data,
    input  logic                   deq,
    input  logic                   clear,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count,
    output T                       head
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);
    localparam logic [AW:0] ONE     = (AW + 1)'(1);

    T            mem_q [DEPTH];
    logic [AW:0] head_q, head_d;
    logic [AW:0] tail_q, tail_d;
    logic        do_enq;

    assign count  = tail_q - head_q;
    assign full   = (count == DEPTH_C);
    assign head   = mem_q[head_q[AW-1:0]];
    assign do_enq = enq & ~full & ~clear;

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        if (clear) begin
            head_d = '0;
            tail_d = '0;
        end else begin
            if (do_enq) tail_d = tail_q + ONE;
            if (deq && count != '0) head_d = head_q + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_enq) mem_q[tail_q[AW-1:0]] <= enq_data;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: one outstanding imem read at a time, results queued for decode.
module fetch_unit
    import rv32i_types::*;
#(
    parameter int          DEPTH    = 8,
    parameter logic [31:0] RESET_PC = 32'h4000_0000
) (
    input  logic                         clk,
    input  logic                         rst,
    output logic [31:0]                  imem_addr,
    output logic                         imem_read,
    input  logic [31:0]                  imem_rdata,
    input  logic                         imem_resp,
    input  logic                         decode_available,
    output logic                         data_out_en,
    output logic [$bits(fetch_queue_t)-1:0] data_out,
    input  logic                         redirect_valid,
    input  logic [31:0]                  redirect_addr,
    input  logic [63:0]                  redirect_order,
    input  logic                         flush_valid,
    input  logic [31:0]                  flush_pc,
    input  logic [63:0]                  flush_order
);
    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_t  state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   addr_q, addr_d;
    logic [63:0]   order_q, order_d;
    logic          enq, deq, fifo_full;
    logic [CW-1:0] count;
    fetch_queue_t  enq_entry, head;
    logic          steer;
    logic [31:0]   steer_pc;
    logic [63:0]   steer_order;

    // Flush outranks redirect; either one squashes everything younger.
    assign steer       = flush_valid | redirect_valid;
    assign steer_pc    = flush_valid ? flush_pc : redirect_addr;
    assign steer_order = flush_valid ? flush_order : redirect_order;

    assign enq_entry = '{inst: imem_rdata, order: order_q, pc: pc_q, pc_next: pc_q + PC_STEP};
    assign deq         = (count != '0) & decode_available & ~steer & ~rst;
    assign data_out_en = deq;
    assign data_out    = (count != '0) ? head : '0;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        addr_d    = addr_q;
        order_d   = order_q;
        imem_read = 1'b0;
        imem_addr = addr_q;
        enq       = 1'b0;
        unique case (state_q)
            REQ: begin
                imem_addr = pc_q;
                if (!fifo_full) begin
                    imem_read = 1'b1;
                    addr_d    = pc_q;
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                imem_read = 1'b1;
                if (imem_resp) begin
                    enq     = ~steer;
                    pc_d    = pc_q + PC_STEP;
                    order_d = order_q + 64'd1;
                    state_d = REQ;
                end
            end
            DROP: begin
                imem_read = 1'b1;
                if (imem_resp) state_d = REQ;
            end
            default: state_d = REQ;
        endcase
        // A read still in flight must be drained before the new target is fetched.
        if (steer) begin
            pc_d    = align_pc(steer_pc);
            order_d = steer_order + 64'd1;
            state_d = (state_q != REQ && !imem_resp) ? DROP : REQ;
        end
        if (rst) imem_read = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= REQ;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
            order_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            order_q <= order_d;
        end
    end

    fetch_fifo #(
        .DEPTH(DEPTH),
        .T    (fetch_queue_t)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .enq     (enq),
        .enq_data(enq_entry),
        .deq     (deq),
        .clear   (steer),
        .full    (fifo_full),
        .count   (count),
        .head    (head)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a simple imem model and a log of entries handed to decode.
module tb_fetch_unit;
    import rv32i_types::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_addr;
    logic        imem_read;
    logic [31:0] imem_rdata;
    logic        imem_resp;
    logic        decode_available;
    logic        data_out_en;
    logic [$bits(fetch_queue_t)-1:0] data_out;
    logic        redirect_valid;
    logic [31:0] redirect_addr;
    logic [63:0] redirect_order;
    logic        flush_valid;
    logic [31:0] flush_pc;
    logic [63:0] flush_order;

    fetch_unit #(.DEPTH(8), .RESET_PC(32'h4000_0000)) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_addr       (imem_addr),
        .imem_read       (imem_read),
        .imem_rdata      (imem_rdata),
        .imem_resp       (imem_resp),
        .decode_available(decode_available),
        .data_out_en     (data_out_en),
        .data_out        (data_out),
        .redirect_valid  (redirect_valid),
        .redirect_addr   (redirect_addr),
        .redirect_order  (redirect_order),
        .flush_valid     (flush_valid),
        .flush_pc        (flush_pc),
        .flush_order     (flush_order)
    );

    always #5 clk = ~clk;

    int           n_tests = 0;
    int           n_fail  = 0;
    int           rd_cnt  = 0;
    logic         mem_auto;
    logic         man_resp;
    logic [31:0]  man_data;
    logic         snap_read, snap_en;
    logic [31:0]  snap_addr;
    logic [$bits(fetch_queue_t)-1:0] snap_data;
    fetch_queue_t got_q[$];

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: memory answers on the 2nd consecutive cycle of imem_read.
    task automatic cycle();
        if (man_resp) begin
            imem_resp  = 1'b1;
            imem_rdata = man_data;
        end else if (mem_auto && imem_read && rd_cnt >= 1) begin
            imem_resp  = 1'b1;
            imem_rdata = inst_of(imem_addr);
        end else begin
            imem_resp  = 1'b0;
            imem_rdata = '0;
        end
        #1;
        snap_read = imem_read;
        snap_addr = imem_addr;
        snap_en   = data_out_en;
        snap_data = data_out;
        if (data_out_en) got_q.push_back(fetch_queue_t'(data_out));
        if (imem_read && !imem_resp) rd_cnt++;
        else rd_cnt = 0;
        man_resp = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_entries(input int n, input int budget);
        for (int i = 0; i < budget && got_q.size() < n; i++) cycle();
    endtask

    task automatic check_entry(input string tag, input int idx, input logic [31:0] pc,
                               input logic [63:0] ord);
        fetch_queue_t e;
        if (got_q.size() > idx) begin
            e = got_q[idx];
            check({tag, ".pc"}, 64'(e.pc), 64'(pc));
            check({tag, ".order"}, e.order, ord);
            check({tag, ".pc_next"}, 64'(e.pc_next), 64'(pc + 32'd4));
            check({tag, ".inst"}, 64'(e.inst), 64'(inst_of(pc)));
        end else begin
            check({tag, ".present"}, 64'(got_q.size()), 64'(idx + 1));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; decode_available = 1'b0;
        redirect_valid = 1'b0; redirect_addr = '0; redirect_order = '0;
        flush_valid = 1'b0; flush_pc = '0; flush_order = '0;
        imem_resp = 1'b0; imem_rdata = '0;
        mem_auto = 1'b0; man_resp = 1'b0; man_data = '0;

        // Reset values
        cycle();
        cycle();
        check("rst.read", 64'(snap_read), 64'd0);
        check("rst.en", 64'(snap_en), 64'd0);
        check("rst.data", 64'(|snap_data), 64'd0);
        check("rst.addr", 64'(snap_addr), 64'h4000_0000);

        // 1: streaming fetch, decode always ready
        rst = 1'b0; decode_available = 1'b1; mem_auto = 1'b1;
        got_q.delete();
        wait_entries(3, 40);
        for (int i = 0; i < 3; i++)
            check_entry("t1", i, 32'h4000_0000 + 32'(4 * i), 64'(i));

        // 2: decode stalls; FIFO fills to DEPTH then drains back-to-back
        decode_available = 1'b0;
        repeat (20) cycle();
        check("t2.no_pop", 64'(got_q.size()), 64'd3);
        check("t2.read_idle", 64'(snap_read), 64'd0);
        mem_auto = 1'b0; decode_available = 1'b1;
        repeat (8) cycle();
        check("t2.burst", 64'(got_q.size()), 64'd11);
        repeat (4) cycle();
        check("t2.exactly8", 64'(got_q.size()), 64'd11);
        for (int i = 3; i < 11; i++)
            check_entry("t2", i, 32'h4000_0000 + 32'(4 * i), 64'(i));

        // 3: redirect held 3 cycles while the read for order 11 is outstanding
        redirect_valid = 1'b1; redirect_addr = 32'h4000_0100; redirect_order = 64'd5;
        repeat (3) begin
            cycle();
            check("t3.en", 64'(snap_en), 64'd0);
            check("t3.hold_addr", 64'(snap_addr), 64'h4000_002C);
        end
        redirect_valid = 1'b0;
        man_resp = 1'b1; man_data = 32'hDEAD_BEEF;
        cycle();
        mem_auto = 1'b1;
        cycle();
        check("t3.new_read", 64'(snap_read), 64'd1);
        check("t3.new_addr", 64'(snap_addr), 64'h4000_0100);
        wait_entries(12, 20);
        check_entry("t3", 11, 32'h4000_0100, 64'd6);

        // 4: flush and redirect together while an entry waits at the head
        cycle();
        flush_valid = 1'b1; flush_pc = 32'h4000_0200; flush_order = 64'd9;
        redirect_valid = 1'b1; redirect_addr = 32'h4000_0300; redirect_order = 64'd20;
        cycle();
        check("t4.en", 64'(snap_en), 64'd0);
        flush_valid = 1'b0; redirect_valid = 1'b0;
        wait_entries(14, 30);
        check_entry("t4a", 12, 32'h4000_0200, 64'd10);
        check_entry("t4b", 13, 32'h4000_0204, 64'd11);

        // 5: response lands in the same cycle as a redirect with a misaligned target
        mem_auto = 1'b0;
        repeat (3) cycle();
        check("t5.idle", 64'(got_q.size()), 64'd14);
        redirect_valid = 1'b1; redirect_addr = 32'h4000_0403; redirect_order = 64'd30;
        man_resp = 1'b1; man_data = 32'h0BAD_F00D;
        cycle();
        redirect_valid = 1'b0;
        cycle();
        check("t5.read", 64'(snap_read), 64'd1);
        check("t5.addr", 64'(snap_addr), 64'h4000_0400);
        mem_auto = 1'b1;
        wait_entries(15, 20);
        check_entry("t5", 14, 32'h4000_0400, 64'd31);

        // 6: reset during WAIT, then a stale response in REQ
        mem_auto = 1'b0;
        repeat (2) cycle();
        rst = 1'b1;
        cycle();
        check("t6.rst_read", 64'(snap_read), 64'd0);
        rst = 1'b0;
        man_resp = 1'b1; man_data = 32'h0BAD_0BAD;
        cycle();
        check("t6.addr", 64'(snap_addr), 64'h4000_0000);
        mem_auto = 1'b1;
        got_q.delete();
        wait_entries(1, 20);
        check_entry("t6", 0, 32'h4000_0000, 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
